native_req_master: RTL and testbench

NATIVE_REQ_MASTER -- requirements
Module: native_req_master

---
 rtl/native_req_master.sv | 187 ++++++++++++++++++
 tb/tb_native_req_master.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/native_req_master.sv
// Command-queued native-port initiator: a small FIFO feeds a one-at-a-time valid/ready issue FSM.
// Optional request watchdog enabled by defining NATIVE_REQ_TIMEOUT_EN.
module native_req_master #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int FIFO_AW     = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_wstrb,
  output logic                  valid,
  output logic [ADDR_W-1:0]     addr,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  input  logic                  ready,
  input  logic [DATA_W-1:0]     rdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_write,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [15:0]           txn_cnt
);
  localparam int NBYTES = DATA_W / 8;
  localparam int DEPTH  = 2 ** FIFO_AW;
  localparam int ENT_W  = ADDR_W + DATA_W + NBYTES;

  if (TIMEOUT_CYC < 1 || (DATA_W % 8) != 0) begin : g_param_chk
    $error("native_req_master: TIMEOUT_CYC must be >= 1 and DATA_W a multiple of 8");
  end

  typedef enum logic [1:0] {IDLE, REQ, RSP, GAP} state_t;

  state_t              state_q, state_d;
  logic [FIFO_AW:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ENT_W-1:0]    mem_q [DEPTH];
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [NBYTES-1:0]   wstrb_q, wstrb_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_write_q, rsp_write_d;
  logic [15:0]         txn_cnt_q, txn_cnt_d;
  logic                empty, full, push, pop;

`ifdef NATIVE_REQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic                rsp_err_q, rsp_err_d;
`endif

  // Extra pointer bit separates full from empty when the index bits match.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                 (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
  assign push  = cmd_valid && !full;

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_write_d = rsp_write_q;
    txn_cnt_d   = txn_cnt_q;
    pop         = 1'b0;
`ifdef NATIVE_REQ_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop                       = 1'b1;
          {addr_d, wdata_d, wstrb_d} = mem_q[rptr_q[FIFO_AW-1:0]];
          valid_d                   = 1'b1;
          state_d                   = REQ;
`ifdef NATIVE_REQ_TIMEOUT_EN
          tmo_cnt_d                 = '0;
`endif
        end
      end
      REQ: begin
`ifdef NATIVE_REQ_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
        if (ready) begin
          valid_d     = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = |wstrb_q;
          rsp_rdata_d = (|wstrb_q) ? '0 : rdata;
          state_d     = RSP;
`ifdef NATIVE_REQ_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
        end
`ifdef NATIVE_REQ_TIMEOUT_EN
        else if (tmo_cnt_d == TMO_W'(TIMEOUT_CYC)) begin
          valid_d     = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = |wstrb_q;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = RSP;
        end
`endif
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          txn_cnt_d   = txn_cnt_q + 16'd1;
          state_d     = GAP;
        end
      end
      default: state_d = IDLE;
    endcase
    wptr_d = wptr_q + {{FIFO_AW{1'b0}}, push};
    rptr_d = rptr_q + {{FIFO_AW{1'b0}}, pop};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      valid_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_write_q <= 1'b0;
      txn_cnt_q   <= '0;
`ifdef NATIVE_REQ_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      valid_q     <= valid_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_write_q <= rsp_write_d;
      txn_cnt_q   <= txn_cnt_d;
`ifdef NATIVE_REQ_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  // Queue storage holds data only; emptiness is tracked by the reset pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[FIFO_AW-1:0]] <= {cmd_addr, cmd_wdata, cmd_wstrb};
  end

  assign cmd_ready = !full;
  assign valid     = valid_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_write = rsp_write_q;
  assign txn_cnt   = txn_cnt_q;
  assign busy      = !empty || (state_q != IDLE);
`ifdef NATIVE_REQ_TIMEOUT_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_native_req_master.sv
// Directed bench for native_req_master: read, write, FIFO fill, response backpressure,
// mid-transaction reset and (with NATIVE_REQ_TIMEOUT_EN) the watchdog.
module tb_native_req_master;
  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        valid, ready;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  wstrb;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic [15:0] txn_cnt;

  int n_checks = 0;
  int n_err    = 0;

  native_req_master #(
    .ADDR_W(32), .DATA_W(32), .FIFO_AW(2), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .ready(ready), .rdata(rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_write(rsp_write), .rsp_err(rsp_err),
    .busy(busy), .txn_cnt(txn_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for the next request, check it, then complete it with a one-cycle ready.
  task automatic serve(input logic [31:0] exp_addr, input int exp_gap, input string tag);
    int n = 0;
    while (!valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, valid, 1);
    check({tag, "_addr"}, addr, exp_addr);
    if (exp_gap >= 0) check({tag, "_gap"}, n, exp_gap);
    ready = 1'b1;
    rdata = exp_addr ^ 32'hFFFF_0000;
    tick();
    ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int ok;
    int n;
    int held;
    int bad;
    reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    ready = 1'b0; rdata = '0; rsp_ready = 1'b1;
    repeat (3) tick();
    check("rst_valid", valid, 0);
    check("rst_addr", addr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_wstrb", wstrb, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_write", rsp_write, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_txn_cnt", txn_cnt, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    tick();
    check("rst_cmd_ready", cmd_ready, 1);

    // Read, responder answers in the third valid cycle
    cmd_valid = 1'b1; cmd_addr = 32'h0000_1234; cmd_wdata = '0; cmd_wstrb = 4'h0;
    tick();
    cmd_valid = 1'b0;
    check("rd_lat_n1_valid", valid, 0);
    check("rd_busy", busy, 1);
    tick();
    check("rd_lat_n2_valid", valid, 1);
    check("rd_addr", addr, 32'h0000_1234);
    check("rd_wstrb", wstrb, 0);
    tick();
    check("rd_hold_valid", valid, 1);
    check("rd_hold_addr", addr, 32'h0000_1234);
    tick();
    check("rd_hold3_valid", valid, 1);
    ready = 1'b1; rdata = 32'hDEAD_BEEF;
    tick();
    ready = 1'b0; rdata = '0;
    check("rd_valid_drop", valid, 0);
    check("rd_rsp_valid", rsp_valid, 1);
    check("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    check("rd_rsp_write", rsp_write, 0);
    check("rd_rsp_err", rsp_err, 0);
    tick();
    check("rd_gap_rsp_valid", rsp_valid, 0);
    check("rd_gap_valid", valid, 0);
    check("rd_txn_cnt", txn_cnt, 1);
    tick();
    check("rd_idle_busy", busy, 0);

    // Write, ready at the first valid cycle
    cmd_valid = 1'b1; cmd_addr = 32'h0000_0579; cmd_wdata = 32'hCAFE_EFAC; cmd_wstrb = 4'hF;
    tick();
    cmd_valid = 1'b0;
    check("wr_lat_n1_valid", valid, 0);
    tick();
    check("wr_valid", valid, 1);
    check("wr_addr", addr, 32'h0000_0579);
    check("wr_wdata", wdata, 32'hCAFE_EFAC);
    check("wr_wstrb", wstrb, 4'hF);
    ready = 1'b1; rdata = 32'h1111_2222;
    tick();
    ready = 1'b0;
    check("wr_valid_one_cycle", valid, 0);
    check("wr_rsp_valid", rsp_valid, 1);
    check("wr_rsp_write", rsp_write, 1);
    check("wr_rsp_rdata", rsp_rdata, 0);
    tick();
    check("wr_txn_cnt", txn_cnt, 2);
    tick();

    // Fill the queue while the first request is stalled
    ok = 0;
    for (int k = 0; k < 5; k++) begin
      if (cmd_ready) ok++;
      cmd_valid = 1'b1; cmd_addr = 32'h100 + 32'(k * 4); cmd_wdata = '0; cmd_wstrb = 4'h0;
      tick();
    end
    check("fill_accept5", ok, 5);
    cmd_addr = 32'h114;
    check("fill_full_ready", cmd_ready, 0);
    check("fill_e0_valid", valid, 1);
    check("fill_e0_addr", addr, 32'h100);
    repeat (3) tick();
    check("fill_full_hold", cmd_ready, 0);
    check("fill_req_stable", addr, 32'h100);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    check("fill_6th_ready", cmd_ready, 1);
    check("fill_pop_spacing", n, 3);
    tick();
    cmd_valid = 1'b0;
    serve(32'h104, -1, "fill_e1");
    serve(32'h108, 3, "fill_e2");
    serve(32'h10C, 3, "fill_e3");
    serve(32'h110, 3, "fill_e4");
    serve(32'h114, 3, "fill_e5");
    repeat (2) tick();
    check("fill_done_busy", busy, 0);
    check("fill_txn_cnt", txn_cnt, 8);

    // Response backpressure
    cmd_valid = 1'b1; cmd_addr = 32'h200; cmd_wstrb = 4'h0;
    tick();
    cmd_addr = 32'h204;
    tick();
    cmd_valid = 1'b0;
    check("bp_a_valid", valid, 1);
    check("bp_a_addr", addr, 32'h200);
    rsp_ready = 1'b0; ready = 1'b1; rdata = 32'h5A5A_0001;
    tick();
    ready = 1'b0;
    held = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid && !valid && rsp_rdata == 32'h5A5A_0001) held++;
      tick();
    end
    check("bp_held_cycles", held, 10);
    check("bp_rsp_still_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    tick();
    check("bp_gap_valid", valid, 0);
    tick();
    check("bp_idle_valid", valid, 0);
    tick();
    check("bp_b_valid", valid, 1);
    check("bp_b_addr", addr, 32'h204);
    check("bp_txn_cnt", txn_cnt, 9);

    // Reset while a request is outstanding and two more are queued
    cmd_valid = 1'b1; cmd_addr = 32'h300;
    tick();
    cmd_addr = 32'h304;
    tick();
    cmd_valid = 1'b0;
    check("rr_pre_valid", valid, 1);
    check("rr_pre_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("rr_async_valid", valid, 0);
    check("rr_async_busy", busy, 0);
    check("rr_async_addr", addr, 0);
    check("rr_async_txn", txn_cnt, 0);
    tick();
    tick();
    reset = 1'b0;
    bad = 0;
    repeat (8) begin
      if (rsp_valid || valid || busy) bad++;
      tick();
    end
    check("rr_no_activity", bad, 0);
    check("rr_cmd_ready", cmd_ready, 1);

`ifdef NATIVE_REQ_TIMEOUT_EN
    // Watchdog: responder never answers
    cmd_valid = 1'b1; cmd_addr = 32'h400; cmd_wstrb = 4'h0;
    tick();
    cmd_valid = 1'b0;
    tick();
    n = 0;
    while (valid && n < 30) begin
      n++;
      tick();
    end
    check("tmo_valid_cycles", n, 8);
    check("tmo_rsp_valid", rsp_valid, 1);
    check("tmo_rsp_err", rsp_err, 1);
    check("tmo_rsp_rdata", rsp_rdata, 0);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
